gear_shift_ctrl: RTL and testbench
==================================

# gear_shift_ctrl

Transmission selector controller that owns the `current_gear` code consumed by the vehicle physics/RPM datapath. It accepts debounced shift-up/shift-down pulses and enforces brake and speed interlocks. Each accepted shift is sequenced through a timed neutral dwell, and rejected requests are reported with a reason code for the display/buzzer logic.

## Interface
- `DWELL_TICKS`, 3: number of `tick_speed` pulses spent in neutral during a shift; legal range 1..15.
- `SPEED_TOL`, 0: maximum speed (km/h) at which shifts into P or R are permitted.
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `engine_on`  in  1  engine running
- `tick_speed`  in  1  single-cycle time base pulse (same as physics update)
- `shift_up`  in  1  single-cycle request toward D (P→R→N→D)
- `shift_down`  in  1  single-cycle request toward P (D→N→R→P)
- `is_brake_normal`, `is_brake_hard`  in  1 each  brake pedal states
- `speed`  in  8  current vehicle speed, km/h
- `current_gear`  out  4  3=P, 6=R, 9=N, 12=D
- `shift_busy`  out  1  high while a dwell is in progress
- `shift_reject`  out  1  one-cycle pulse when a request is refused
- `reject_code`  out  3  reason, valid with `shift_reject`, held until next reject

## Operation
- State machine states:
  - `PARK`, `REV`, `NEUT`, `DRIVE`: steady states.
  - `SHIFT`: dwell state. It holds a registered `target` and outputs gear 9.
- Brake means `is_brake_normal | is_brake_hard`.
- Interlock rules:
  - P→R: requires brake and `speed <= SPEED_TOL`.
  - N→R: requires brake and `speed <= SPEED_TOL`.
  - R→P: requires `speed <= SPEED_TOL`.
  - R→N, N→D, D→N: always allowed.
- Reject codes, with precedence in this order:
  - 4 NO_ENGINE: `engine_on`=0.
  - 6 CONFLICT: `shift_up` and `shift_down` in the same cycle.
  - 5 BUSY: request arrives while in `SHIFT`.
  - 1 LIMIT: up from D, or down from P.
  - 3 SPEED: speed rule violated.
  - 2 NO_BRAKE: brake rule violated.
- Reset state: `reject_code` 0 (none) until the first reject.
- Accepted shift with target N: go directly to `NEUT` with no dwell.
- Accepted shift with any other target: enter `SHIFT` and clear the dwell counter.
  - Count `tick_speed` pulses.
  - On the `DWELL_TICKS`-th pulse, re-check the speed rule for target P/R.
  - If the rule passes, go to the target state.
  - If it fails, go to `NEUT` and pulse reject with code 3.
- `engine_on` falling while in `SHIFT`: abort to `NEUT`; no reject pulse.
- A request arriving in the same cycle as the dwell completes is BUSY-rejected.
- Speed arithmetic is unsigned 8-bit compare only; no subtraction.

## Timing
- Reset values:
  - `current_gear`=3, state `PARK`.
  - `shift_busy`=0, `shift_reject`=0, `reject_code`=0.
  - Dwell counter 0.
- All outputs are registered. A request sampled at edge k has its effect visible after edge k+1:
  - Reject: `shift_reject`=1 for exactly one cycle; `reject_code` is updated on the same edge.
  - Accept to N: `current_gear`=9.
  - Accept to other targets: `current_gear`=9 and `shift_busy`=1.
- Dwell completion: the edge that samples the `DWELL_TICKS`-th `tick_speed` updates `current_gear` to the target and drops `shift_busy`.
  - Total neutral time therefore depends on tick phase; it is never less than `DWELL_TICKS`-1 full tick periods.
- `rst` asserted mid-shift: immediately returns to P; no completion and no reject.
- `tick_speed` and a request in the same cycle: the request is evaluated against the pre-edge state; a steady state does not count the tick.

## Configuration
- `GEAR_AUTO_PARK_EN` defined:
  - While `engine_on`=0, `speed` <= `SPEED_TOL`, and the state is not `PARK` or `SHIFT`, the next edge forces `PARK` (gear 3).
  - Combined with the mid-shift abort, an engine-off during a dwell at standstill reaches P two cycles later.
- `GEAR_AUTO_PARK_EN` undefined: the gear holds when the engine stops; only explicit shifts (rejected with NO_ENGINE while off) change it.

## Structure
- Shared package `gear_pkg` holds:
  - Gear code constants (`GEAR_P`=3, `GEAR_R`=6, `GEAR_N`=9, `GEAR_D`=12).
  - Reject code constants 0..6.
  - The state enum.
  - The physics block imports the same gear constants.
- One combinational sub-module, `shift_interlock`, takes current gear, direction, `speed`, brake and `engine_on`. It returns allow/next-target/reject_code.
  - The dwell FSM and counter stay in `gear_shift_ctrl`.
  - The completion re-check reuses `shift_interlock`.

## Test plan
- Reset, then `shift_up` with brake=0, speed=0, engine on → reject pulse, code 2, gear stays 3.
- Brake=1, speed=0, `shift_up` → next cycle gear 9 and busy=1; after 3 `tick_speed` pulses gear 6, busy 0.
- From R: `shift_up` → gear 9 next cycle, busy 0. Then `shift_up` → gear 9, busy, and after the dwell gear 12. Then `shift_up` → reject code 1.
- In D at speed 40: `shift_down` → N. Then `shift_down` with brake → reject code 3. Then a request during an active dwell → code 5. Then `shift_up` and `shift_down` together → code 6.
- P→R accepted, then speed raised to 5 before the 3rd tick → gear 9 and reject code 3 at completion.
- With `GEAR_AUTO_PARK_EN`: gear D, speed 0, `engine_on` dropped → gear 3 within 1 cycle. Without the macro, gear stays 12 and `shift_down` rejects with code 4.

Source files
------------

// File: rtl/gear_pkg.sv
// Shared gear/reject code constants and controller state encoding for the
// transmission selector and the physics datapath that consumes current_gear.
package gear_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    localparam logic [2:0] REJ_NONE      = 3'd0;
    localparam logic [2:0] REJ_LIMIT     = 3'd1;
    localparam logic [2:0] REJ_NO_BRAKE  = 3'd2;
    localparam logic [2:0] REJ_SPEED     = 3'd3;
    localparam logic [2:0] REJ_NO_ENGINE = 3'd4;
    localparam logic [2:0] REJ_BUSY      = 3'd5;
    localparam logic [2:0] REJ_CONFLICT  = 3'd6;

    typedef enum logic [2:0] {
        ST_PARK,
        ST_REV,
        ST_NEUT,
        ST_DRIVE,
        ST_SHIFT
    } gear_state_t;

    // SHIFT presents neutral to the driveline while the dwell runs
    function automatic logic [3:0] state_gear(input gear_state_t s);
        case (s)
            ST_PARK:  return GEAR_P;
            ST_REV:   return GEAR_R;
            ST_DRIVE: return GEAR_D;
            default:  return GEAR_N;
        endcase
    endfunction

    function automatic gear_state_t gear_state(input logic [3:0] g);
        case (g)
            GEAR_P:  return ST_PARK;
            GEAR_R:  return ST_REV;
            GEAR_D:  return ST_DRIVE;
            default: return ST_NEUT;
        endcase
    endfunction

endpackage

// File: rtl/shift_interlock.sv
// Combinational shift request arbiter: decides whether a request from the
// given gear may proceed, which gear it targets, and why it is refused.
module shift_interlock
    import gear_pkg::*;
#(
    parameter int SPEED_TOL = 0
) (
    input  logic [3:0] gear,
    input  logic       shift_up,
    input  logic       shift_down,
    input  logic       busy,
    input  logic [7:0] speed,
    input  logic       brake,
    input  logic       engine_on,
    output logic       allow,
    output logic [3:0] next_target,
    output logic [2:0] reject_code
);

    localparam logic [7:0] TOL = 8'(SPEED_TOL);

    logic speed_ok;
    assign speed_ok = (speed <= TOL);

    // Precedence: engine, conflict, busy, limit, speed, brake
    always_comb begin
        allow       = 1'b0;
        next_target = gear;
        reject_code = REJ_NONE;
        if (shift_up | shift_down) begin
            if (!engine_on) begin
                reject_code = REJ_NO_ENGINE;
            end else if (shift_up & shift_down) begin
                reject_code = REJ_CONFLICT;
            end else if (busy) begin
                reject_code = REJ_BUSY;
            end else begin
                case (gear)
                    GEAR_P: begin
                        if (shift_down) begin
                            reject_code = REJ_LIMIT;
                        end else begin
                            next_target = GEAR_R;
                            if (!speed_ok)   reject_code = REJ_SPEED;
                            else if (!brake) reject_code = REJ_NO_BRAKE;
                            else             allow = 1'b1;
                        end
                    end
                    GEAR_R: begin
                        if (shift_up) begin
                            next_target = GEAR_N;
                            allow       = 1'b1;
                        end else begin
                            next_target = GEAR_P;
                            if (!speed_ok) reject_code = REJ_SPEED;
                            else           allow = 1'b1;
                        end
                    end
                    GEAR_N: begin
                        if (shift_up) begin
                            next_target = GEAR_D;
                            allow       = 1'b1;
                        end else begin
                            next_target = GEAR_R;
                            if (!speed_ok)   reject_code = REJ_SPEED;
                            else if (!brake) reject_code = REJ_NO_BRAKE;
                            else             allow = 1'b1;
                        end
                    end
                    GEAR_D: begin
                        if (shift_up) begin
                            reject_code = REJ_LIMIT;
                        end else begin
                            next_target = GEAR_N;
                            allow       = 1'b1;
                        end
                    end
                    default: reject_code = REJ_LIMIT;
                endcase
            end
        end
    end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Transmission selector FSM with timed neutral dwell and reject reporting.
// Optional GEAR_AUTO_PARK_EN: force PARK when the engine is off at standstill.
//
// state    | meaning
// PARK     | steady, gear 3
// REV      | steady, gear 6
// NEUT     | steady, gear 9
// DRIVE    | steady, gear 12
// SHIFT    | dwell in neutral toward registered target
module gear_shift_ctrl
    import gear_pkg::*;
#(
    parameter int DWELL_TICKS = 3,
    parameter int SPEED_TOL   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       engine_on,
    input  logic       tick_speed,
    input  logic       shift_up,
    input  logic       shift_down,
    input  logic       is_brake_normal,
    input  logic       is_brake_hard,
    input  logic [7:0] speed,
    output logic [3:0] current_gear,
    output logic       shift_busy,
    output logic       shift_reject,
    output logic [2:0] reject_code
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);

    gear_state_t state, state_nx;
    logic [3:0]  target, target_nx;
    logic [3:0]  dwell_cnt, dwell_cnt_nx;
    logic [3:0]  gear_nx;
    logic        busy_nx, rej_nx;
    logic [2:0]  code_nx;

    logic        req_allow, chk_allow;
    logic [3:0]  req_target, chk_target;
    logic [2:0]  req_code, chk_code;
    logic [3:0]  chk_from;
    logic        chk_up;

    shift_interlock #(.SPEED_TOL(SPEED_TOL)) u_req (
        .gear        (current_gear),
        .shift_up    (shift_up),
        .shift_down  (shift_down),
        .busy        (state == ST_SHIFT),
        .speed       (speed),
        .brake       (is_brake_normal | is_brake_hard),
        .engine_on   (engine_on),
        .allow       (req_allow),
        .next_target (req_target),
        .reject_code (req_code)
    );

    // Completion re-check replays the move into the target with the brake
    // forced, so only the speed rule can fail (R->P, N->R, N->D).
    assign chk_up   = (target == GEAR_D);
    assign chk_from = (target == GEAR_P) ? GEAR_R : GEAR_N;

    shift_interlock #(.SPEED_TOL(SPEED_TOL)) u_chk (
        .gear        (chk_from),
        .shift_up    (chk_up),
        .shift_down  (!chk_up),
        .busy        (1'b0),
        .speed       (speed),
        .brake       (1'b1),
        .engine_on   (1'b1),
        .allow       (chk_allow),
        .next_target (chk_target),
        .reject_code (chk_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_PARK;
            target       <= GEAR_P;
            dwell_cnt    <= 4'd0;
            current_gear <= GEAR_P;
            shift_busy   <= 1'b0;
            shift_reject <= 1'b0;
            reject_code  <= REJ_NONE;
        end else begin
            state        <= state_nx;
            target       <= target_nx;
            dwell_cnt    <= dwell_cnt_nx;
            current_gear <= gear_nx;
            shift_busy   <= busy_nx;
            shift_reject <= rej_nx;
            reject_code  <= code_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        target_nx    = target;
        dwell_cnt_nx = dwell_cnt;
        rej_nx       = 1'b0;
        code_nx      = reject_code;
        if (req_code != REJ_NONE) begin
            rej_nx  = 1'b1;
            code_nx = req_code;
        end
        if (state == ST_SHIFT) begin
            if (!engine_on) begin
                state_nx = ST_NEUT;
            end else if (tick_speed) begin
                if (dwell_cnt == DWELL_LAST) begin
                    if (chk_allow) begin
                        state_nx = gear_state(chk_target);
                    end else begin
                        state_nx = ST_NEUT;
                        // a same-cycle BUSY reject outranks the speed failure
                        if (!rej_nx) begin
                            rej_nx  = 1'b1;
                            code_nx = chk_code;
                        end
                    end
                end else begin
                    dwell_cnt_nx = dwell_cnt + 4'd1;
                end
            end
        end else begin
            if (req_allow) begin
                if (req_target == GEAR_N) begin
                    state_nx = ST_NEUT;
                end else begin
                    state_nx     = ST_SHIFT;
                    target_nx    = req_target;
                    dwell_cnt_nx = 4'd0;
                end
            end
`ifdef GEAR_AUTO_PARK_EN
            if (!engine_on && (speed <= 8'(SPEED_TOL)) && (state != ST_PARK))
                state_nx = ST_PARK;
`endif
        end
        gear_nx = state_gear(state_nx);
        busy_nx = (state_nx == ST_SHIFT);
    end

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Self-checking bench for gear_shift_ctrl: directed plan plus random traffic
// compared every cycle against a gear-index reference model.
module tb_gear_shift_ctrl;

    localparam int DWELL = 3;
    localparam int TOL   = 0;

    logic       clk;
    logic       rst;
    logic       engine_on;
    logic       tick_speed;
    logic       shift_up;
    logic       shift_down;
    logic       brk_n;
    logic       brk_h;
    logic [7:0] speed;
    logic [3:0] current_gear;
    logic       shift_busy;
    logic       shift_reject;
    logic [2:0] reject_code;

    gear_shift_ctrl #(.DWELL_TICKS(DWELL), .SPEED_TOL(TOL)) dut (
        .clk             (clk),
        .rst             (rst),
        .engine_on       (engine_on),
        .tick_speed      (tick_speed),
        .shift_up        (shift_up),
        .shift_down      (shift_down),
        .is_brake_normal (brk_n),
        .is_brake_hard   (brk_h),
        .speed           (speed),
        .current_gear    (current_gear),
        .shift_busy      (shift_busy),
        .shift_reject    (shift_reject),
        .reject_code     (reject_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Gear index 0..3 = P,R,N,D; up is +1, down is -1
    int gear_code[4] = '{3, 6, 9, 12};
    int m_idx, m_shift, m_tgt, m_ticks, m_rej, m_code;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_shift = 0; m_tgt = 0; m_ticks = 0; m_rej = 0; m_code = 0;
    endtask

    task automatic model_update();
        int  nidx, code;
        bit  up, dn, sok, brk;
        up  = shift_up;
        dn  = shift_down;
        sok = (int'(speed) <= TOL);
        brk = brk_n | brk_h;
        m_rej = 0;
        if (m_shift != 0) begin
            if (up || dn) begin
                m_rej  = 1;
                m_code = !engine_on ? 4 : ((up && dn) ? 6 : 5);
            end
            if (!engine_on) begin
                m_shift = 0;
                m_idx   = 2;
            end else if (tick_speed) begin
                m_ticks++;
                if (m_ticks == DWELL) begin
                    m_shift = 0;
                    if (m_tgt <= 1 && !sok) begin
                        m_idx = 2;
                        if (m_rej == 0) begin
                            m_rej  = 1;
                            m_code = 3;
                        end
                    end else begin
                        m_idx = m_tgt;
                    end
                end
            end
        end else begin
            if (up || dn) begin
                nidx = m_idx + (up ? 1 : -1);
                if (!engine_on)                code = 4;
                else if (up && dn)             code = 6;
                else if (nidx < 0 || nidx > 3) code = 1;
                else if (nidx <= 1 && !sok)    code = 3;
                else if (nidx == 1 && !brk)    code = 2;
                else                           code = 0;
                if (code != 0) begin
                    m_rej  = 1;
                    m_code = code;
                end else if (nidx == 2) begin
                    m_idx = 2;
                end else begin
                    m_shift = 1;
                    m_tgt   = nidx;
                    m_ticks = 0;
                end
            end
`ifdef GEAR_AUTO_PARK_EN
            if (!engine_on && sok && m_idx != 0) m_idx = 0;
`endif
        end
    endtask

    task automatic compare();
        check("gear", current_gear, (m_shift != 0) ? 9 : gear_code[m_idx]);
        check("busy", shift_busy, m_shift);
        check("reject", shift_reject, m_rej);
        check("code", reject_code, m_code);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit up, input bit dn, input bit tk, input bit brk,
                         input int spd, input bit eng);
        shift_up   = up;
        shift_down = dn;
        tick_speed = tk;
        brk_n      = brk;
        brk_h      = 1'b0;
        speed      = 8'(spd);
        engine_on  = eng;
        step();
    endtask

    task automatic dwell(input int spd);
        for (int i = 0; i < DWELL; i++) drive(0, 0, 1, 0, spd, 1);
    endtask

    logic [7:0] spd_tab[6] = '{8'd0, 8'd0, 8'd1, 8'd5, 8'd40, 8'd255};

    initial begin
        model_reset();
        rst = 1'b1;
        shift_up = 0; shift_down = 0; tick_speed = 0; brk_n = 0; brk_h = 0;
        speed = 0; engine_on = 1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        check("rst_gear", current_gear, 3);
        check("rst_busy", shift_busy, 0);
        check("rst_rej", shift_reject, 0);
        check("rst_code", reject_code, 0);
        rst = 1'b0;

        drive(1, 0, 0, 0, 0, 1);
        check("nobrake_rej", shift_reject, 1);
        check("nobrake_code", reject_code, 2);
        check("nobrake_gear", current_gear, 3);

        drive(1, 0, 0, 1, 0, 1);
        check("p2r_gear", current_gear, 9);
        check("p2r_busy", shift_busy, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        check("p2r_still_busy", shift_busy, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        check("p2r_done_gear", current_gear, 6);
        check("p2r_done_busy", shift_busy, 0);

        drive(1, 0, 0, 0, 0, 1);
        check("r2n_gear", current_gear, 9);
        check("r2n_busy", shift_busy, 0);
        drive(1, 0, 0, 0, 0, 1);
        check("n2d_busy", shift_busy, 1);
        dwell(0);
        check("n2d_gear", current_gear, 12);
        drive(1, 0, 0, 0, 0, 1);
        check("limit_code", reject_code, 1);

        drive(0, 1, 0, 0, 40, 1);
        check("d2n_gear", current_gear, 9);
        drive(0, 1, 0, 1, 40, 1);
        check("speed_code", reject_code, 3);
        drive(1, 0, 0, 0, 40, 1);
        drive(0, 1, 0, 0, 40, 1);
        check("busy_code", reject_code, 5);
        drive(1, 1, 0, 0, 40, 1);
        check("conflict_code", reject_code, 6);
        dwell(40);
        check("n2d_fast_gear", current_gear, 12);

        drive(0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0, 1);
        dwell(0);
        drive(0, 1, 0, 0, 0, 1);
        dwell(0);
        check("r2p_gear", current_gear, 3);

        drive(1, 0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 5, 1);
        drive(0, 0, 1, 0, 5, 1);
        check("recheck_gear", current_gear, 9);
        check("recheck_rej", shift_reject, 1);
        check("recheck_code", reject_code, 3);

        drive(1, 0, 0, 0, 5, 1);
        dwell(5);
        check("d_again", current_gear, 12);
        drive(0, 0, 0, 0, 0, 0);
`ifdef GEAR_AUTO_PARK_EN
        check("autopark_gear", current_gear, 3);
`else
        check("engoff_hold", current_gear, 12);
        drive(0, 1, 0, 0, 0, 0);
        check("noeng_code", reject_code, 4);
        check("noeng_gear", current_gear, 12);
`endif
        drive(0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 4000; n++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            shift_up   = ($urandom_range(0, 99) < 15);
            shift_down = ($urandom_range(0, 99) < 15);
            tick_speed = ($urandom_range(0, 99) < 30);
            brk_n      = ($urandom_range(0, 1) == 1);
            brk_h      = ($urandom_range(0, 3) == 0);
            speed      = spd_tab[$urandom_range(0, 5)];
            engine_on  = ($urandom_range(0, 99) < 92);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
